// File: rtl/nco_capture.sv
// Sample sink for the NCO stream: buffers 12-bit samples in a FIFO and drains
// each one as MSB-first 2-bit digits over a Svld/Sack pin handshake.
module nco_capture #(
  parameter int DW    = 12,
  parameter int SW    = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     En,
  input  logic                     Rdy,
  input  logic [DW-1:0]            Din,
  input  logic                     Clr,
  input  logic                     Sack,
  output logic [SW-1:0]            Sout,
  output logic                     Svld,
  output logic                     Sfrm,
  output logic                     Ovf,
  output logic [$clog2(DEPTH):0]   Cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NDIG = DW / SW;
  localparam int DCW  = $clog2(NDIG + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [DW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic [DW-1:0]    r_shreg, w_shreg_next;
  logic [DCW-1:0]   r_dig, w_dig_next;
  logic             r_svld, r_sfrm, r_ovf;

  logic w_empty, w_full, w_last, w_pop, w_advance;
  logic w_push_req, w_push, w_drop;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == (AW+1)'(DEPTH));
  assign w_last     = (r_dig == DCW'(NDIG - 1));
  assign w_push_req = Rdy & En;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (Sack) begin
          w_advance = 1'b1;
          if (w_last) begin
            if (!w_empty) w_pop = 1'b1;
            else          w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_shreg_next = r_shreg;
    w_dig_next   = r_dig;
    if (w_pop) begin
      w_shreg_next = r_mem[r_rd_ptr];
      w_dig_next   = '0;
    end else if (w_advance) begin
      w_shreg_next = {r_shreg[DW-SW-1:0], {SW{1'b0}}};
      w_dig_next   = w_last ? '0 : r_dig + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_dig    <= '0;
      r_svld   <= 1'b0;
      r_sfrm   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shreg <= w_shreg_next;
      r_dig   <= w_dig_next;
      r_svld  <= (w_state_next == SHIFT);
      r_sfrm  <= (w_state_next == SHIFT) && (w_dig_next == '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // Set wins over a same-cycle clear.
      if (w_drop)   r_ovf <= 1'b1;
      else if (Clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= Din;
  end

  assign Sout = r_shreg[DW-1 -: SW];
  assign Svld = r_svld;
  assign Sfrm = r_sfrm;
  assign Ovf  = r_ovf;
  assign Cnt  = r_cnt;
endmodule
